// File: rtl/interrupt_sequencer.sv
// Seven-cycle interrupt entry sequencer: reset, NMI, IRQ and BRK share one
// T1..T7 timeline (two dummy reads, three stack cycles, two vector reads).
module interrupt_sequencer (
  input  logic       clk,
  input  logic       clr,
  input  logic       irq,
  input  logic       nmi,
  input  logic       idis,
  input  logic       instend,
  input  logic       brk,
  output logic       busy,
  output logic [2:0] step,
  output logic       rw,
  output logic       pushpch,
  output logic       pushpcl,
  output logic       pushp,
  output logic       spdec,
  output logic       setreset,
  output logic       setnmi,
  output logic       setirq,
  output logic       vecfetch,
  output logic       bflag,
  output logic       setirqdis,
  output logic       ack
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_T1   = 3'd1;
  localparam logic [2:0] S_T2   = 3'd2;
  localparam logic [2:0] S_T3   = 3'd3;
  localparam logic [2:0] S_T4   = 3'd4;
  localparam logic [2:0] S_T5   = 3'd5;
  localparam logic [2:0] S_T6   = 3'd6;
  localparam logic [2:0] S_T7   = 3'd7;

  localparam logic [1:0] K_RESET = 2'd0;
  localparam logic [1:0] K_NMI   = 2'd1;
  localparam logic [1:0] K_IRQ   = 2'd2;
  localparam logic [1:0] K_BRK   = 2'd3;

  logic [2:0] state_q, state_d;
  logic [1:0] kind_q, kind_d;
  logic       brk_q, brk_d;
  logic       nmi_pend_q, nmi_pend_d;
  logic       nmi_prev_q;
  logic       rst_pend_q, rst_pend_d;
  logic       nmi_edge;
  logic       nmi_clr;

  always_comb begin
    state_d    = state_q;
    kind_d     = kind_q;
    brk_d      = brk_q;
    rst_pend_d = rst_pend_q;
    nmi_clr    = 1'b0;
    nmi_edge   = nmi & ~nmi_prev_q;
    case (state_q)
      S_IDLE: begin
        if (rst_pend_q) begin
          state_d    = S_T1;
          kind_d     = K_RESET;
          brk_d      = 1'b0;
          rst_pend_d = 1'b0;
        end else if (instend) begin
          if (nmi_pend_q) begin
            state_d = S_T1;
            kind_d  = K_NMI;
            brk_d   = 1'b0;
            nmi_clr = 1'b1;
          end else if (irq && !idis) begin
            state_d = S_T1;
            kind_d  = K_IRQ;
            brk_d   = 1'b0;
          end else if (brk) begin
            state_d = S_T1;
            kind_d  = K_BRK;
            brk_d   = 1'b1;
          end
        end
      end
      S_T7: state_d = S_IDLE;
      default: begin
        state_d = state_q + 3'd1;
        // A pending NMI seen by T5 redirects the vector fetch; bflag keeps its value.
        if (state_q == S_T5 && nmi_pend_q && (kind_q == K_IRQ || kind_q == K_BRK)) begin
          kind_d  = K_NMI;
          nmi_clr = 1'b1;
        end
      end
    endcase
    nmi_pend_d = nmi_edge | (nmi_pend_q & ~nmi_clr);
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q    <= S_IDLE;
      kind_q     <= K_RESET;
      brk_q      <= 1'b0;
      nmi_pend_q <= 1'b0;
      nmi_prev_q <= 1'b0;
      rst_pend_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      kind_q     <= kind_d;
      brk_q      <= brk_d;
      nmi_pend_q <= nmi_pend_d;
      nmi_prev_q <= nmi;
      rst_pend_q <= rst_pend_d;
    end
  end

  // Output decode from registered state only.
  always_comb begin
    busy      = (state_q != S_IDLE);
    step      = state_q;
    rw        = 1'b1;
    pushpch   = 1'b0;
    pushpcl   = 1'b0;
    pushp     = 1'b0;
    spdec     = 1'b0;
    setreset  = 1'b0;
    setnmi    = 1'b0;
    setirq    = 1'b0;
    vecfetch  = 1'b0;
    bflag     = (state_q != S_IDLE) & brk_q;
    setirqdis = 1'b0;
    ack       = 1'b0;
    case (state_q)
      S_T3, S_T4, S_T5: begin
        spdec = 1'b1;
        if (kind_q != K_RESET) begin
          rw      = 1'b0;
          pushpch = (state_q == S_T3);
          pushpcl = (state_q == S_T4);
          pushp   = (state_q == S_T5);
        end
      end
      S_T6, S_T7: begin
        vecfetch  = 1'b1;
        setreset  = (kind_q == K_RESET);
        setnmi    = (kind_q == K_NMI);
        setirq    = (kind_q == K_IRQ) || (kind_q == K_BRK);
        setirqdis = (state_q == S_T7);
        ack       = (state_q == S_T7);
      end
      default: ;
    endcase
  end

endmodule
